usb_fs_tx_arbiter: RTL
======================

// Module: usb_fs_tx_arbiter
// PURPOSE
//  Shares the single USB FS transmitter between NUM_REQ packet sources (endpoint handshake logic, IN data endpoints).
//  Round-robin arbitration; one clk-domain packet at a time: issues pkt_start/pid, routes the winner's byte stream, waits for pkt_end.
//  Sits between the endpoint blocks and usb_fs_tx (clk side); enforces an inter-packet gap and a stuck-packet timeout.
// PARAMETERS
//  NUM_REQ        2     number of requesters (>=2)
//  GAP_CYCLES     16    clk cycles idle after pkt_end before next grant (>=1)
//  TIMEOUT_CYCLES 4096  max clk cycles in BUSY awaiting pkt_end before abort (power of 2)
// PORTS
//  clk             in   1          system clock; single clock domain
//  reset           in   1          synchronous, active-high
//  req             in   NUM_REQ    per-requester packet request (level; held until done/abort)
//  req_pid         in   4*NUM_REQ  PID of each requester, slice i = [4i+3:4i]
//  req_data_avail  in   NUM_REQ    per-requester byte available
//  req_data        in   8*NUM_REQ  per-requester byte, slice i = [8i+7:8i]
//  req_data_get    out  NUM_REQ    byte-consumed strobe, routed to granted requester only
//  grant           out  NUM_REQ    one-hot registered grant
//  done            out  NUM_REQ    1-cycle pulse: packet of requester i finished normally
//  abort           out  NUM_REQ    1-cycle pulse: packet of requester i timed out
//  pkt_start       out  1          1-cycle start pulse to transmitter
//  pid             out  4          registered PID of granted packet
//  tx_data_avail   out  1          granted requester's avail; 0 when no grant
//  tx_data         out  8          granted requester's byte; 0 when no grant
//  tx_data_get     in   1          transmitter byte-consumed strobe
//  pkt_end         in   1          transmitter end-of-packet strobe
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, done=0, abort=0, pkt_start=0, pid=0, rr_ptr=0, counters=0; all outputs 0 the cycle after reset.
//  States: IDLE -> START -> BUSY -> GAP -> IDLE.
//  IDLE: if |req, winner = first set req index scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ;
//   next cycle grant[winner]=1, pid<=req_pid[winner], state=START. No req: stay.
//  START: pkt_start=1 for exactly this cycle; state=BUSY; timeout counter cleared.
//  BUSY: tx_data_avail/tx_data = combinational mux of granted slice; req_data_get = grant & {NUM_REQ{tx_data_get}}.
//   pkt_end -> done[winner] pulse next cycle, grant=0, rr_ptr=(winner+1) mod NUM_REQ, state=GAP.
//   counter reaches TIMEOUT_CYCLES-1 without pkt_end -> abort[winner] pulse, grant=0, rr_ptr advances, state=GAP.
//   pkt_end and timeout in same cycle: pkt_end wins (done, not abort).
//  GAP: count GAP_CYCLES cycles, then IDLE; req ignored; pkt_end/tx_data_get ignored.
//  Grant latency: req sampled in IDLE -> grant 1 cycle later -> pkt_start 2 cycles later.
//  Requester deasserting req in START/BUSY: no effect; packet runs to pkt_end/timeout.
//  pkt_end outside BUSY: ignored. tx_data_get with no grant: no req_data_get asserted.
//  Reset mid-packet: immediate return to IDLE, grant dropped, no done/abort pulse.
//  rr_ptr wraps NUM_REQ-1 -> 0; counters sized $clog2 of their limits, saturate never reached.
// STRUCTURE
//  Shared include usb_defs.vh: PID constants (ACK/NAK/STALL/DATA0/DATA1), arbiter state encodings.
//  One sub-module: usb_rr_pick (combinational round-robin picker: req, rr_ptr -> winner index, valid).
//  Remainder (FSM, counters, data mux) lives in this module.
// TESTING
//  1. req=01, pid0=ACK(0x2), pkt_end 3 cycles after start -> grant=01, pkt_start 1 pulse, pid=0x2, done=01 pulse, GAP_CYCLES idle.
//  2. req=11 held continuously -> grants alternate 01,10,01,10; each pkt_start separated by >=GAP_CYCLES+2 cycles.
//  3. Granted req 1 streams bytes 0xA5,0x5A; tx_data_get pulses -> req_data_get=10 on each; req_data_get[0] never asserted.
//  4. No pkt_end for TIMEOUT_CYCLES -> abort pulse for winner, grant=0, next request served after gap.
//  5. reset asserted in BUSY -> next cycle grant=0, pkt_start=0, no done/abort; rr_ptr=0 so req=11 grants 01 first.
//  6. pkt_end coincident with timeout edge -> done pulse, abort stays 0.

Source files
------------

// File: rtl/usb_fs_tx_arbiter_pkg.sv
// ============================================================================
// Module  : usb_fs_tx_arbiter_pkg
// Brief   : Shared PID constants and arbiter state encoding for the FS TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_fs_tx_arbiter_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/usb_rr_pick.sv
// ============================================================================
// Module  : usb_rr_pick
// Brief   : Combinational round-robin picker; first set request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            automatic int          k   = (int'(rr_ptr_i) + i) % NUM_REQ;
            automatic logic [IW-1:0] k_w = IW'(k);
            if (req_i[k_w]) begin
                idx_o   = k_w;
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_fs_tx_arbiter.sv
// ============================================================================
// Module  : usb_fs_tx_arbiter
// Brief   : Round-robin sharing of the USB FS transmitter with gap and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_fs_tx_arbiter
    import usb_fs_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [4*NUM_REQ-1:0]   req_pid_i,
    input  logic [NUM_REQ-1:0]     req_data_avail_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_data_get_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     abort_o,
    output logic                   pkt_start_o,
    output logic [3:0]             pid_o,
    output logic                   tx_data_avail_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_data_get_i,
    input  logic                   pkt_end_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] abort_q, abort_d;
    logic               pkt_start_q, pkt_start_d;
    logic [3:0]         pid_q, pid_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [3:0]         pick_pid;
    logic [IW-1:0]      next_ptr;

    usb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        pick_pid = 4'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_pid = req_pid_i[4*i +: 4];
            end
        end
    end

    assign next_ptr = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            abort_q     <= '0;
            pkt_start_q <= 1'b0;
            pid_q       <= 4'h0;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            tmo_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            pkt_start_q <= pkt_start_d;
            pid_q       <= pid_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        abort_d     = '0;
        pkt_start_d = 1'b0;
        pid_d       = pid_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    win_d             = pick_idx;
                    pid_d             = pick_pid;
                    state_d           = ST_START;
                end
            end
            ST_START: begin
                pkt_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = ST_BUSY;
            end
            ST_BUSY: begin
                // End of packet takes priority over a timeout landing on the same cycle.
                if (pkt_end_i) begin
                    done_d   = grant_q;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    abort_d  = grant_q;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_data_avail_o = 1'b0;
        tx_data_o       = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                tx_data_avail_o = tx_data_avail_o | req_data_avail_i[i];
                tx_data_o       = tx_data_o | req_data_i[8*i +: 8];
            end
        end
    end

    assign req_data_get_o = (state_q == ST_BUSY) ? (grant_q & {NUM_REQ{tx_data_get_i}}) : '0;

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign abort_o     = abort_q;
    assign pkt_start_o = pkt_start_q;
    assign pid_o       = pid_q;

endmodule

`default_nettype wire
